memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares the single main-memory port between the instruction-side and data-side L1 caches. Each cache drives the same memory-side interface it would drive to a dedicated memory. The arbiter grants one requester at a time, forwards its signals to memory and routes the memory's ready pulse back to it only. Data side has priority, with a bounded-streak rule so instruction fetch is never starved.

## Interface
- `MAX_D_STREAK`, default 4: consecutive data grants allowed while an instruction request waits; range 1–15.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `iAddress` in 32: instruction requester address.
- `iReadEnable` in 1: instruction read request (level).
- `iReady` out 1: memory ready routed to instruction side.
- `dAddress` in 32: data requester address.
- `dDataOut` in 32: data requester write data.
- `dReadEnable` in 1: data read request (level).
- `dWriteEnable` in 1: data write request (level).
- `dReady` out 1: memory ready routed to data side.
- `readData` out 32: `memoryDataIn` broadcast to both requesters.
- `memoryAddress` out 32: memory address.
- `memoryDataOut` out 32: memory write data.
- `memoryReadEnable` out 1: memory read strobe.
- `memoryWriteEnable` out 1: memory write strobe.
- `memoryDataIn` in 32: memory read data.
- `memoryReady` in 1: memory completion pulse.
- `grantI`, `grantD` out 1 each: current owner, for stall logic and debug.

## Operation
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Encoding is 2 bits.
- IDLE arbitration at each edge:
  - Requests: `reqD = dReadEnable|dWriteEnable`; `reqI = iReadEnable`.
  - Only reqD → GRANT_D. Only reqI → GRANT_I. Neither → stay in IDLE.
  - Both: GRANT_I if `dStreak == MAX_D_STREAK`, else GRANT_D.
- GRANT_x:
  - Memory outputs are muxed from requester x, and the other requester is fully isolated.
  - When `memoryReady` = 1: `xReady` = `memoryReady` in the same cycle (combinational), and next state is RELEASE.
  - Otherwise stay in GRANT_x indefinitely. There is no timeout.
- RELEASE: memory enables are forced to 0 for one cycle, then → IDLE. This guarantees memory sees an enable gap between transactions.
- `dStreak` counter:
  - On a GRANT_D decision with reqI = 1: increment, saturating at `MAX_D_STREAK`.
  - On any GRANT_I decision, or a GRANT_D decision with reqI = 0: clear to 0.
- In IDLE and RELEASE, all memory outputs are 0 (address and data zeroed).
- If a requester asserts both read and write, it is treated as a write: `memoryReadEnable` = 0, `memoryWriteEnable` = 1.
- `memoryReady` outside a GRANT state is ignored; `iReady`/`dReady` stay 0.
- A request still asserted when the arbiter returns to IDLE is a new transaction. Requesters must drop their enables within one cycle of their ready pulse unless they want another access.
- Requesters must hold address, data and enables stable from assertion until their ready. Dropping a request mid-grant aborts it: the arbiter stays in GRANT_x with enables low, and the next `memoryReady` still routes to x.

## Timing
- Reset values:
  - `state` = IDLE, `dStreak` = 0.
  - `grantI`, `grantD`, `iReady`, `dReady`, `memoryReadEnable`, `memoryWriteEnable` = 0.
  - `memoryAddress`, `memoryDataOut` = 0.
- Reset asserted mid-grant: memory enables drop immediately (asynchronous), and the transaction is lost. Requesters re-request after reset.
- Grant latency: a request present at edge N drives memory enables from cycle N+1. The grant is registered, and the output mux is combinational from state.
- Ready path: `memoryReady` → `xReady` is combinational, zero-cycle.
- Back-to-back: ready at cycle k → RELEASE at k+1 → IDLE at k+2. The next grant is visible at k+3. Minimum 3-cycle turnaround per transaction beyond memory latency.
- `readData` is valid to requester x only in the cycle `xReady` = 1.

## Structure
- Package `memory_arbiter_pkg`:
  - State enum: `ARB_IDLE`, `ARB_GRANT_I`, `ARB_GRANT_D`, `ARB_RELEASE`.
  - Constant `ARB_STREAK_W` = 4.
- Sub-module `arb_priority_select` (combinational): inputs reqI, reqD, dStreak, `MAX_D_STREAK`; outputs pickI, pickD. The top level holds the FSM, streak counter and output muxes.

## Test plan
- Single I read at 0x40, memory ready after 3 cycles with data 0xDEADBEEF → `memoryReadEnable` high for cycles 1–3; `iReady` pulses with `readData` = 0xDEADBEEF; `dReady` stays 0.
- Simultaneous I and D requests at cycle 0 → D granted first. I is granted at D-ready+3, and its `memoryAddress` equals `iAddress`.
- `MAX_D_STREAK` = 2, D requesting continuously and I requesting → grant order D, D, I, D, D, I.
- D write 0x1234 to 0x80 with read and write both high → memory sees write=1, read=0, data 0x1234.
- Reset pulsed mid GRANT_D → enables fall in the same cycle; after release, `state` is IDLE, `dStreak` = 0 and all outputs are 0.
- `memoryReady` pulsed while IDLE, then back-to-back D requests → no ready routed; one RELEASE cycle with enables low between the two D transactions.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the instruction/data main-memory arbiter.
package memory_arbiter_pkg;

    localparam int ARB_STREAK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2,
        ARB_RELEASE = 2'd3
    } arbState_t;

endpackage

// File: rtl/arb_priority_select.sv
// Arbitration decision for an idle memory port: data first, unless the
// instruction side has already waited through MAX_D_STREAK data grants.
module arb_priority_select
    import memory_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                    reqI,
    input  logic                    reqD,
    input  logic [ARB_STREAK_W-1:0] dStreak,
    output logic                    pickI,
    output logic                    pickD
);

    localparam logic [ARB_STREAK_W-1:0] MAX_STREAK = ARB_STREAK_W'(MAX_D_STREAK);

    // Choose one requester; instruction wins a tie only once the streak limit is hit.
    always_comb begin
        pickI = 1'b0;
        pickD = 1'b0;
        if (reqD && !(reqI && (dStreak == MAX_STREAK))) begin
            pickD = 1'b1;
        end else if (reqI) begin
            pickI = 1'b1;
        end else begin
            pickI = 1'b0;
            pickD = 1'b0;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one main-memory port between the instruction and data L1 caches,
// with a registered grant FSM and a combinational output/ready mux.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iAddress,
    input  logic        iReadEnable,
    output logic        iReady,
    input  logic [31:0] dAddress,
    input  logic [31:0] dDataOut,
    input  logic        dReadEnable,
    input  logic        dWriteEnable,
    output logic        dReady,
    output logic [31:0] readData,
    output logic [31:0] memoryAddress,
    output logic [31:0] memoryDataOut,
    output logic        memoryReadEnable,
    output logic        memoryWriteEnable,
    input  logic [31:0] memoryDataIn,
    input  logic        memoryReady,
    output logic        grantI,
    output logic        grantD
);

    localparam logic [ARB_STREAK_W-1:0] MAX_STREAK  = ARB_STREAK_W'(MAX_D_STREAK);
    localparam logic [ARB_STREAK_W-1:0] STREAK_ZERO = {ARB_STREAK_W{1'b0}};
    localparam logic [ARB_STREAK_W-1:0] STREAK_ONE  = {{(ARB_STREAK_W-1){1'b0}}, 1'b1};

    arbState_t               state_r;
    arbState_t               nextState_s;
    logic [ARB_STREAK_W-1:0] dStreak_r;
    logic [ARB_STREAK_W-1:0] dStreakNext_s;
    logic                    reqI_s;
    logic                    reqD_s;
    logic                    pickI_s;
    logic                    pickD_s;

    assign reqI_s = iReadEnable;
    assign reqD_s = dReadEnable | dWriteEnable;

    arb_priority_select #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_select (
        .reqI    (reqI_s),
        .reqD    (reqD_s),
        .dStreak (dStreak_r),
        .pickI   (pickI_s),
        .pickD   (pickD_s)
    );

    // Next grant state and streak count; the streak only moves on an IDLE decision.
    always_comb begin
        nextState_s   = state_r;
        dStreakNext_s = dStreak_r;
        case (state_r)
            ARB_IDLE: begin
                if (pickD_s) begin
                    nextState_s = ARB_GRANT_D;
                    if (!reqI_s) begin
                        dStreakNext_s = STREAK_ZERO;
                    end else if (dStreak_r < MAX_STREAK) begin
                        dStreakNext_s = dStreak_r + STREAK_ONE;
                    end else begin
                        dStreakNext_s = MAX_STREAK;
                    end
                end else if (pickI_s) begin
                    nextState_s   = ARB_GRANT_I;
                    dStreakNext_s = STREAK_ZERO;
                end else begin
                    nextState_s = ARB_IDLE;
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                if (memoryReady) begin
                    nextState_s = ARB_RELEASE;
                end else begin
                    nextState_s = state_r;
                end
            end
            ARB_RELEASE: nextState_s = ARB_IDLE;
            default:     nextState_s = ARB_IDLE;
        endcase
    end

    // Grant state and streak registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ARB_IDLE;
            dStreak_r <= STREAK_ZERO;
        end else begin
            state_r   <= nextState_s;
            dStreak_r <= dStreakNext_s;
        end
    end

    // Route the owner's signals to memory and memory's ready back to the owner only.
    always_comb begin
        memoryAddress     = 32'd0;
        memoryDataOut     = 32'd0;
        memoryReadEnable  = 1'b0;
        memoryWriteEnable = 1'b0;
        iReady            = 1'b0;
        dReady            = 1'b0;
        grantI            = 1'b0;
        grantD            = 1'b0;
        case (state_r)
            ARB_GRANT_I: begin
                grantI           = 1'b1;
                memoryAddress    = iAddress;
                memoryReadEnable = iReadEnable;
                iReady           = memoryReady;
            end
            ARB_GRANT_D: begin
                grantD            = 1'b1;
                memoryAddress     = dAddress;
                memoryDataOut     = dDataOut;
                // A simultaneous read+write request is carried out as a write.
                memoryWriteEnable = dWriteEnable;
                memoryReadEnable  = dReadEnable & ~dWriteEnable;
                dReady            = memoryReady;
            end
            default: begin
                grantI = 1'b0;
                grantD = 1'b0;
            end
        endcase
    end

    assign readData = memoryDataIn;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (instantiated with MAX_D_STREAK = 2).
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iAddress;
    logic        iReadEnable;
    logic        iReady;
    logic [31:0] dAddress;
    logic [31:0] dDataOut;
    logic        dReadEnable;
    logic        dWriteEnable;
    logic        dReady;
    logic [31:0] readData;
    logic [31:0] memoryAddress;
    logic [31:0] memoryDataOut;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic [31:0] memoryDataIn;
    logic        memoryReady;
    logic        grantI;
    logic        grantD;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    memory_arbiter #(
        .MAX_D_STREAK (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .iAddress          (iAddress),
        .iReadEnable       (iReadEnable),
        .iReady            (iReady),
        .dAddress          (dAddress),
        .dDataOut          (dDataOut),
        .dReadEnable       (dReadEnable),
        .dWriteEnable      (dWriteEnable),
        .dReady            (dReady),
        .readData          (readData),
        .memoryAddress     (memoryAddress),
        .memoryDataOut     (memoryDataOut),
        .memoryReadEnable  (memoryReadEnable),
        .memoryWriteEnable (memoryWriteEnable),
        .memoryDataIn      (memoryDataIn),
        .memoryReady       (memoryReady),
        .grantI            (grantI),
        .grantD            (grantD)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkVal({tag, "_re"},    {31'd0, memoryReadEnable},  32'd0);
        checkVal({tag, "_we"},    {31'd0, memoryWriteEnable}, 32'd0);
        checkVal({tag, "_addr"},  memoryAddress,              32'd0);
        checkVal({tag, "_data"},  memoryDataOut,              32'd0);
        checkVal({tag, "_grant"}, {30'd0, grantD, grantI},    32'd0);
        checkVal({tag, "_ready"}, {30'd0, dReady, iReady},    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] order;

        reset        = 1'b1;
        iAddress     = 32'd0;
        iReadEnable  = 1'b0;
        dAddress     = 32'd0;
        dDataOut     = 32'd0;
        dReadEnable  = 1'b0;
        dWriteEnable = 1'b0;
        memoryDataIn = 32'd0;
        memoryReady  = 1'b0;

        // Reset state
        tick();
        tick();
        checkIdleOutputs("reset");
        reset = 1'b0;

        // Single instruction read, memory ready on the third granted cycle
        iAddress    = 32'h0000_0040;
        iReadEnable = 1'b1;
        #1;
        checkVal("i_idle_re", {31'd0, memoryReadEnable}, 32'd0);
        tick();
        checkVal("i_c1_re",    {31'd0, memoryReadEnable}, 32'd1);
        checkVal("i_c1_addr",  memoryAddress,             32'h0000_0040);
        checkVal("i_c1_grant", {30'd0, grantD, grantI},   32'd1);
        tick();
        checkVal("i_c2_re",    {31'd0, memoryReadEnable}, 32'd1);
        checkVal("i_c2_ready", {31'd0, iReady},           32'd0);
        tick();
        memoryReady  = 1'b1;
        memoryDataIn = 32'hDEAD_BEEF;
        #1;
        checkVal("i_c3_re",    {31'd0, memoryReadEnable}, 32'd1);
        checkVal("i_c3_iready", {31'd0, iReady},          32'd1);
        checkVal("i_c3_dready", {31'd0, dReady},          32'd0);
        checkVal("i_c3_rdata", readData,                  32'hDEAD_BEEF);
        iReadEnable = 1'b0;
        tick();
        memoryReady = 1'b0;
        checkIdleOutputs("i_release");
        tick();

        // Simultaneous requests: data first, instruction at D-ready + 3
        iAddress    = 32'h0000_0100;
        dAddress    = 32'h0000_0200;
        iReadEnable = 1'b1;
        dReadEnable = 1'b1;
        tick();
        checkVal("both_grant", {30'd0, grantD, grantI}, 32'd2);
        checkVal("both_addr",  memoryAddress,           32'h0000_0200);
        memoryReady = 1'b1;
        #1;
        checkVal("both_dready", {30'd0, dReady, iReady}, 32'd2);
        dReadEnable = 1'b0;
        tick();
        memoryReady = 1'b0;
        checkVal("both_k1_grant", {30'd0, grantD, grantI}, 32'd0);
        tick();
        checkVal("both_k2_re", {31'd0, memoryReadEnable}, 32'd0);
        tick();
        checkVal("both_k3_grant", {30'd0, grantD, grantI}, 32'd1);
        checkVal("both_k3_addr",  memoryAddress,           32'h0000_0100);
        memoryReady = 1'b1;
        #1;
        checkVal("both_iready", {30'd0, dReady, iReady}, 32'd1);
        iReadEnable = 1'b0;
        tick();
        memoryReady = 1'b0;
        tick();

        // Streak limit 2 with both sides requesting: D, D, I, D, D, I
        order       = 6'b011011;
        iAddress    = 32'h0000_0500;
        dAddress    = 32'h0000_0400;
        iReadEnable = 1'b1;
        dReadEnable = 1'b1;
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < 10 && !(grantI || grantD); c++) begin
                tick();
            end
            checkVal("stream_grant", {30'd0, grantD, grantI}, order[t] ? 32'd2 : 32'd1);
            checkVal("stream_addr", memoryAddress, order[t] ? 32'h0000_0400 : 32'h0000_0500);
            memoryReady = 1'b1;
            tick();
            memoryReady = 1'b0;
            checkVal("stream_gap", {31'd0, memoryReadEnable}, 32'd0);
        end
        iReadEnable = 1'b0;
        dReadEnable = 1'b0;
        tick();

        // Data write with read also asserted is carried out as a write
        dAddress     = 32'h0000_0080;
        dDataOut     = 32'h0000_1234;
        dReadEnable  = 1'b1;
        dWriteEnable = 1'b1;
        tick();
        checkVal("wr_we",   {31'd0, memoryWriteEnable}, 32'd1);
        checkVal("wr_re",   {31'd0, memoryReadEnable},  32'd0);
        checkVal("wr_data", memoryDataOut,              32'h0000_1234);
        checkVal("wr_addr", memoryAddress,              32'h0000_0080);
        memoryReady = 1'b1;
        #1;
        dReadEnable  = 1'b0;
        dWriteEnable = 1'b0;
        tick();
        memoryReady = 1'b0;
        tick();

        // Reset asserted mid data grant, with a non-zero streak
        iReadEnable = 1'b1;
        dReadEnable = 1'b1;
        dAddress    = 32'h0000_0600;
        tick();
        checkVal("rst_pre_re",     {31'd0, memoryReadEnable}, 32'd1);
        checkVal("rst_pre_streak", {28'd0, dut.dStreak_r},    32'd1);
        reset = 1'b1;
        #1;
        checkVal("rst_async_re",    {31'd0, memoryReadEnable}, 32'd0);
        checkVal("rst_async_grant", {30'd0, grantD, grantI},   32'd0);
        iReadEnable = 1'b0;
        dReadEnable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checkVal("rst_state",  {30'd0, dut.state_r},   32'd0);
        checkVal("rst_streak", {28'd0, dut.dStreak_r}, 32'd0);
        checkIdleOutputs("rst_after");

        // Stray memoryReady while idle, then back-to-back data reads
        memoryReady = 1'b1;
        #1;
        checkVal("stray_ready", {30'd0, dReady, iReady}, 32'd0);
        tick();
        memoryReady = 1'b0;
        checkVal("stray_grant", {30'd0, grantD, grantI}, 32'd0);
        dAddress    = 32'h0000_0300;
        dReadEnable = 1'b1;
        tick();
        checkVal("b2b_first_grant", {30'd0, grantD, grantI}, 32'd2);
        memoryReady = 1'b1;
        #1;
        checkVal("b2b_first_dready", {31'd0, dReady}, 32'd1);
        tick();
        memoryReady = 1'b0;
        checkVal("b2b_release_re",    {31'd0, memoryReadEnable}, 32'd0);
        checkVal("b2b_release_grant", {30'd0, grantD, grantI},   32'd0);
        tick();
        checkVal("b2b_idle_re", {31'd0, memoryReadEnable}, 32'd0);
        tick();
        checkVal("b2b_second_re",   {31'd0, memoryReadEnable}, 32'd1);
        checkVal("b2b_second_addr", memoryAddress,             32'h0000_0300);
        memoryReady = 1'b1;
        #1;
        checkVal("b2b_second_dready", {31'd0, dReady}, 32'd1);
        dReadEnable = 1'b0;
        tick();
        memoryReady = 1'b0;
        tick();
        checkIdleOutputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
